// File: rtl/beat_timer.sv
// Note-duration timer for the buzzer path: decodes a beat descriptor into a
// sound phase and a silent articulation gap, gating the tone generator.
module beat_timer #(
   parameter int WHOLE_CYC = 50_000_000,
   parameter int CNT_W     = 28,
   parameter int GAP_CYC   = 500_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       note_valid,
   output logic       note_ready,
   input  logic [3:0] beat,
   input  logic       dotted,
   input  logic       rest,
   input  logic [1:0] speed,
   input  logic       pause,
   input  logic       abort,
   output logic       tone_en,
   output logic       busy,
   output logic       note_done,
   output logic       bad_beat,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SOUND = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] WHOLE_W = CNT_W'(WHOLE_CYC);
   localparam logic [CNT_W-1:0] GAP_W   = CNT_W'(GAP_CYC);
   localparam logic [CNT_W-1:0] ONE_W   = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] gap_q, gap_d;
   logic             rest_q, rest_d;
   logic             done_q, done_d;
   logic             bad_q, bad_d;

   logic             beat_ok;
   logic             accept;
   logic [CNT_W-1:0] base_w, dot_w, spd_w, dur_w, sound_w, gap_w;

   // Descriptor decode; only consumed on the accept cycle.
   always_comb begin
      beat_ok = (beat >= 4'd1) && (beat <= 4'd6);
      base_w  = WHOLE_W >> (beat - 4'd1);
      dot_w   = dotted ? (base_w + (base_w >> 1)) : base_w;
      case (speed)
         2'b01:   spd_w = dot_w << 1;
         2'b10:   spd_w = dot_w >> 1;
         default: spd_w = dot_w;
      endcase
      dur_w = (spd_w == '0) ? ONE_W : spd_w;
      if (dur_w > GAP_W) begin
         sound_w = dur_w - GAP_W;
         gap_w   = GAP_W;
      end else begin
         sound_w = dur_w;
         gap_w   = '0;
      end
   end

   // Handshake: a descriptor transfers on a cycle with note_valid & note_ready;
   // the source must hold it stable until then. abort vetoes the transfer.
   assign accept = note_valid & note_ready & ~abort;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         gap_q   <= '0;
         rest_q  <= 1'b0;
         done_q  <= 1'b0;
         bad_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         rest_q  <= rest_d;
         done_q  <= done_d;
         bad_q   <= bad_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      rest_d  = rest_q;
      done_d  = 1'b0;
      bad_d   = 1'b0;
      if (abort) begin
         state_d = IDLE;
         cnt_d   = '0;
         gap_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (beat_ok) begin
                     state_d = SOUND;
                     cnt_d   = sound_w;
                     gap_d   = gap_w;
                     rest_d  = rest;
                  end else begin
                     bad_d = 1'b1;
                  end
               end
            end
            SOUND: begin
               if (!pause) begin
                  if (cnt_q <= ONE_W) begin
                     if (gap_q != '0) begin
                        state_d = GAP;
                        cnt_d   = gap_q;
                     end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                     end
                  end else begin
                     cnt_d = cnt_q - ONE_W;
                  end
               end
            end
            GAP: begin
               if (!pause) begin
                  if (cnt_q <= ONE_W) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                     done_d  = 1'b1;
                  end else begin
                     cnt_d = cnt_q - ONE_W;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      note_ready = (state_q == IDLE) & ~pause & ~rst;
      tone_en    = (state_q == SOUND) & ~rest_q & ~pause;
      busy       = (state_q == SOUND) | (state_q == GAP);
      note_done  = done_q;
      bad_beat   = bad_q;
      dbg_state  = state_q;
   end

endmodule

// File: tb/tb_beat_timer.sv
// Self-checking bench for beat_timer: directed scenarios plus randomized notes
// compared cycle by cycle against a timeline model of each note.
module tb_beat_timer;

   localparam int WHOLE = 64;
   localparam int GAP   = 2;
   localparam int CW    = 10;

   logic       clk = 1'b0;
   logic       rst;
   logic       note_valid;
   logic       note_ready;
   logic [3:0] beat;
   logic       dotted;
   logic       rest;
   logic [1:0] speed;
   logic       pause;
   logic       abort;
   logic       tone_en;
   logic       busy;
   logic       note_done;
   logic       bad_beat;
   logic [1:0] dbg_state;

   int n_cmp = 0;
   int n_bad = 0;

   // Per-cycle observation / expectation: {ready, tone, busy, done, bad}
   logic [4:0] exp_q[$];
   logic [4:0] obs_q[$];

   beat_timer #(.WHOLE_CYC(WHOLE), .CNT_W(CW), .GAP_CYC(GAP)) dut (
      .clk(clk), .rst(rst), .note_valid(note_valid), .note_ready(note_ready),
      .beat(beat), .dotted(dotted), .rest(rest), .speed(speed),
      .pause(pause), .abort(abort), .tone_en(tone_en), .busy(busy),
      .note_done(note_done), .bad_beat(bad_beat), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog");
   end

   // Note length in cycles from the musical rules; 0 means an invalid beat.
   function automatic int model_dur(input int b, input bit dt, input int sp);
      int d;
      if (b < 1 || b > 6) return 0;
      d = WHOLE / (1 << (b - 1));
      if (dt) d = d + d / 2;
      if (sp == 1) d = d * 2;
      else if (sp == 2) d = d / 2;
      if (d == 0) d = 1;
      return d;
   endfunction

   // Expected timeline: p is how far the note has progressed (1 = first sound
   // cycle), advancing only on unpaused cycles.
   task automatic build_exp(input int d, input bit rs, input int lo, input int hi,
                            input int kill_k, input int rst_k, input int ncyc,
                            input bit done0);
      int snd, p;
      bit paused, idle, killed, dn_seen;
      logic [4:0] e;
      snd = (d > GAP) ? d - GAP : d;
      exp_q.delete();
      exp_q.push_back({1'b1, 1'b0, 1'b0, done0, 1'b0});
      p = 1;
      dn_seen = 1'b0;
      for (int c = 1; c <= ncyc; c++) begin
         paused = (c >= lo) && (c <= hi);
         killed = (kill_k >= 0 && c > kill_k) || (rst_k >= 0 && c > rst_k);
         idle   = (d == 0) || killed || (p > d);
         e[4] = idle && !paused && (c != rst_k);
         e[3] = !idle && (p <= snd) && !rs && !paused;
         e[2] = !idle;
         e[1] = (d != 0) && !killed && (p == d + 1) && !dn_seen;
         e[0] = (d == 0) && (c == 1) && (kill_k != 0) && (rst_k != 0);
         if (e[1]) dn_seen = 1'b1;
         if (!paused && p <= d) p++;
         exp_q.push_back(e);
      end
   endtask

   // Drives one descriptor at k=0 and records outputs for k=0..ncyc.
   // Entered and left just after a rising edge.
   task automatic play_note(input int b, input bit dt, input bit rs, input int sp,
                            input int lo, input int hi, input int kill_k, input int rst_k,
                            input int ncyc, input bit hold, input int nb, input bit nd,
                            input bit nr, input int ns);
      obs_q.delete();
      for (int k = 0; k <= ncyc; k++) begin
         if (k == 0) begin
            note_valid = 1'b1;
            beat = 4'(b); dotted = dt; rest = rs; speed = 2'(sp);
            pause = 1'b0;
         end else begin
            note_valid = hold;
            if (hold) begin
               beat = 4'(nb); dotted = nd; rest = nr; speed = 2'(ns);
            end else begin
               beat = 4'($urandom_range(0, 15)); dotted = 1'($urandom_range(0, 1));
               rest = 1'($urandom_range(0, 1)); speed = 2'($urandom_range(0, 3));
            end
            pause = (k >= lo) && (k <= hi);
         end
         abort = (k == kill_k);
         rst   = (k == rst_k);
         @(negedge clk);
         obs_q.push_back({note_ready, tone_en, busy, note_done, bad_beat});
         @(posedge clk);
         #1;
      end
      note_valid = 1'b0; pause = 1'b0; abort = 1'b0; rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; note_valid = 1'b0; beat = 4'd0; dotted = 1'b0; rest = 1'b0;
      speed = 2'd0; pause = 1'b0; abort = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({note_ready, tone_en, busy, note_done, bad_beat} !== 5'b00000) begin
         n_bad++;
         $display("FAIL reset_held: got %b want 00000", {note_ready, tone_en, busy, note_done, bad_beat});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({note_ready, tone_en, busy, note_done, bad_beat} !== 5'b10000) begin
         n_bad++;
         $display("FAIL reset_release: got %b want 10000", {note_ready, tone_en, busy, note_done, bad_beat});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_quarter();
      int done_at, tones;
      build_exp(model_dur(3, 0, 0), 0, 0, -1, -1, -1, 18, 0);
      play_note(3, 0, 0, 0, 0, -1, -1, -1, 18, 0, 0, 0, 0, 0);
      done_at = -1; tones = 0;
      for (int k = 0; k < obs_q.size(); k++) begin
         n_cmp++;
         if (obs_q[k] !== exp_q[k]) begin
            n_bad++;
            $display("FAIL quarter k=%0d: got %b want %b", k, obs_q[k], exp_q[k]);
         end
         if (obs_q[k][1] && done_at < 0) done_at = k;
         if (obs_q[k][3]) tones++;
      end
      n_cmp++;
      if (done_at !== 17) begin
         n_bad++;
         $display("FAIL quarter_done_cycle: got %0d want 17", done_at);
      end
      n_cmp++;
      if (tones !== 14) begin
         n_bad++;
         $display("FAIL quarter_tone_len: got %0d want 14", tones);
      end
   endtask

   task automatic test_dotted_speed();
      int done_at, tones;
      build_exp(model_dur(3, 1, 1), 0, 0, -1, -1, -1, 50, 0);
      play_note(3, 1, 0, 1, 0, -1, -1, -1, 50, 0, 0, 0, 0, 0);
      done_at = -1; tones = 0;
      for (int k = 0; k < obs_q.size(); k++) begin
         n_cmp++;
         if (obs_q[k] !== exp_q[k]) begin
            n_bad++;
            $display("FAIL dotted_slow k=%0d: got %b want %b", k, obs_q[k], exp_q[k]);
         end
         if (obs_q[k][1] && done_at < 0) done_at = k;
         if (obs_q[k][3]) tones++;
      end
      n_cmp++;
      if (done_at !== 49 || tones !== 46) begin
         n_bad++;
         $display("FAIL dotted_slow_shape: got done=%0d tone=%0d want done=49 tone=46", done_at, tones);
      end
      build_exp(model_dur(6, 0, 2), 0, 0, -1, -1, -1, 3, 0);
      play_note(6, 0, 0, 2, 0, -1, -1, -1, 3, 0, 0, 0, 0, 0);
      for (int k = 0; k < obs_q.size(); k++) begin
         n_cmp++;
         if (obs_q[k] !== exp_q[k]) begin
            n_bad++;
            $display("FAIL t32_fast k=%0d: got %b want %b", k, obs_q[k], exp_q[k]);
         end
      end
      n_cmp++;
      if (obs_q[2][1] !== 1'b1 || obs_q[1][3] !== 1'b1) begin
         n_bad++;
         $display("FAIL t32_fast_shape: got tone1=%b done2=%b want 1 1", obs_q[1][3], obs_q[2][1]);
      end
   endtask

   task automatic test_back_to_back();
      build_exp(model_dur(4, 0, 0), 1, 0, -1, -1, -1, 8, 0);
      play_note(4, 0, 1, 0, 0, -1, -1, -1, 8, 1, 3, 0, 0, 0);
      for (int k = 0; k < obs_q.size(); k++) begin
         n_cmp++;
         if (obs_q[k] !== exp_q[k]) begin
            n_bad++;
            $display("FAIL rest_eighth k=%0d: got %b want %b", k, obs_q[k], exp_q[k]);
         end
      end
      build_exp(model_dur(3, 0, 0), 0, 0, -1, -1, -1, 18, 1);
      play_note(3, 0, 0, 0, 0, -1, -1, -1, 18, 0, 0, 0, 0, 0);
      for (int k = 0; k < obs_q.size(); k++) begin
         n_cmp++;
         if (obs_q[k] !== exp_q[k]) begin
            n_bad++;
            $display("FAIL back_to_back k=%0d: got %b want %b", k, obs_q[k], exp_q[k]);
         end
      end
   endtask

   task automatic test_bad_beat();
      int codes[2] = '{0, 9};
      foreach (codes[i]) begin
         build_exp(model_dur(codes[i], 0, 0), 0, 0, -1, -1, -1, 3, 0);
         play_note(codes[i], 0, 0, 0, 0, -1, -1, -1, 3, 0, 0, 0, 0, 0);
         for (int k = 0; k < obs_q.size(); k++) begin
            n_cmp++;
            if (obs_q[k] !== exp_q[k]) begin
               n_bad++;
               $display("FAIL bad_beat code=%0d k=%0d: got %b want %b", codes[i], k, obs_q[k], exp_q[k]);
            end
         end
      end
   endtask

   task automatic test_pause();
      int done_at;
      build_exp(model_dur(3, 0, 0), 0, 5, 9, -1, -1, 23, 0);
      play_note(3, 0, 0, 0, 5, 9, -1, -1, 23, 0, 0, 0, 0, 0);
      done_at = -1;
      for (int k = 0; k < obs_q.size(); k++) begin
         n_cmp++;
         if (obs_q[k] !== exp_q[k]) begin
            n_bad++;
            $display("FAIL pause k=%0d: got %b want %b", k, obs_q[k], exp_q[k]);
         end
         if (obs_q[k][1] && done_at < 0) done_at = k;
      end
      n_cmp++;
      if (done_at !== 22) begin
         n_bad++;
         $display("FAIL pause_done_cycle: got %0d want 22", done_at);
      end
      pause = 1'b1; note_valid = 1'b1; beat = 4'd3;
      @(negedge clk);
      n_cmp++;
      if (note_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL pause_idle_ready: got %b want 0", note_ready);
      end
      @(posedge clk); #1;
      pause = 1'b0; note_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL pause_idle_accept: busy got %b want 0", busy);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_abort();
      build_exp(model_dur(2, 0, 0), 0, 0, -1, 6, -1, 10, 0);
      play_note(2, 0, 0, 0, 0, -1, 6, -1, 10, 0, 0, 0, 0, 0);
      for (int k = 0; k < obs_q.size(); k++) begin
         n_cmp++;
         if (obs_q[k] !== exp_q[k]) begin
            n_bad++;
            $display("FAIL abort_half k=%0d: got %b want %b", k, obs_q[k], exp_q[k]);
         end
      end
      build_exp(model_dur(3, 0, 0), 0, 0, -1, 0, -1, 3, 0);
      play_note(3, 0, 0, 0, 0, -1, 0, -1, 3, 0, 0, 0, 0, 0);
      for (int k = 0; k < obs_q.size(); k++) begin
         n_cmp++;
         if (obs_q[k] !== exp_q[k]) begin
            n_bad++;
            $display("FAIL abort_accept k=%0d: got %b want %b", k, obs_q[k], exp_q[k]);
         end
      end
      build_exp(model_dur(3, 0, 0), 0, 0, -1, -1, 5, 7, 0);
      play_note(3, 0, 0, 0, 0, -1, -1, 5, 7, 0, 0, 0, 0, 0);
      for (int k = 0; k < obs_q.size(); k++) begin
         n_cmp++;
         if (obs_q[k] !== exp_q[k]) begin
            n_bad++;
            $display("FAIL rst_mid_note k=%0d: got %b want %b", k, obs_q[k], exp_q[k]);
         end
      end
   endtask

   task automatic test_random();
      int b, sp, d, lo, hi, kk, nc;
      bit dt, rs;
      for (int i = 0; i < 25; i++) begin
         b  = $urandom_range(0, 9);
         dt = 1'($urandom_range(0, 1));
         rs = 1'($urandom_range(0, 1));
         sp = $urandom_range(0, 3);
         d  = model_dur(b, dt, sp);
         lo = 0; hi = -1; kk = -1;
         if (d > 0 && $urandom_range(0, 1) == 1) begin
            lo = $urandom_range(1, d);
            hi = lo + $urandom_range(0, 4);
         end
         if (d > 0 && $urandom_range(0, 3) == 0) kk = $urandom_range(1, d);
         nc = d + (hi - lo + 1) + 2;
         build_exp(d, rs, lo, hi, kk, -1, nc, 0);
         play_note(b, dt, rs, sp, lo, hi, kk, -1, nc, 0, 0, 0, 0, 0);
         for (int k = 0; k < obs_q.size(); k++) begin
            n_cmp++;
            if (obs_q[k] !== exp_q[k]) begin
               n_bad++;
               $display("FAIL random i=%0d beat=%0d dot=%0d rest=%0d spd=%0d k=%0d: got %b want %b",
                        i, b, dt, rs, sp, k, obs_q[k], exp_q[k]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_quarter();
      test_dotted_speed();
      test_back_to_back();
      test_bad_beat();
      test_pause();
      test_abort();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
